// File: rtl/mycpu_pkg.sv
// Shared CPU package: default datapath widths and the hard-wired zero register.
package mycpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int NFWD_DEF = 3;
    localparam int PW_DEF   = 64;

    // GPR 0 always reads as zero and is never a real dependency.
    localparam logic [AW_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/ds_operand_stage_if.sv
// Decode-stage instruction bus: upstream accept side (in_*) and downstream
// issue side (out_*).
//
// Handshake: a transfer happens on a rising clk edge where valid and allowin
// are both 1. valid is not allowed to depend combinationally on allowin from
// the same side. The instruction is held stable while valid is 1 and allowin
// is 0, unless it is killed by flush.
interface ds_operand_stage_if
    import mycpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int PW   = PW_DEF
);

    logic            in_valid;
    logic            in_allowin;
    logic [AW-1:0]   in_rs;
    logic [AW-1:0]   in_rt;
    logic            in_rs_used;
    logic            in_rt_used;
    logic [AW-1:0]   in_dest;
    logic            in_we;
    logic [PW-1:0]   in_payload;

    logic            out_valid;
    logic            out_allowin;
    logic [XLEN-1:0] out_rs_value;
    logic [XLEN-1:0] out_rt_value;
    logic [AW-1:0]   out_dest;
    logic            out_we;
    logic [PW-1:0]   out_payload;

    // Stage side: consumes the upstream instruction, produces the issue bundle.
    modport slave (
        input  in_valid, in_rs, in_rt, in_rs_used, in_rt_used, in_dest, in_we, in_payload,
        output in_allowin,
        output out_valid, out_rs_value, out_rt_value, out_dest, out_we, out_payload,
        input  out_allowin
    );

    // Environment side: decode drives in_*, execute consumes out_*.
    modport master (
        output in_valid, in_rs, in_rt, in_rs_used, in_rt_used, in_dest, in_we, in_payload,
        input  in_allowin,
        input  out_valid, out_rs_value, out_rt_value, out_dest, out_we, out_payload,
        output out_allowin
    );

endinterface

// File: rtl/ds_fwd_select.sv
// One source operand: youngest-first producer match and value mux.
module ds_fwd_select
    import mycpu_pkg::*;
#(
    parameter int NFWD = NFWD_DEF,
    parameter int AW   = AW_DEF,
    parameter int XLEN = XLEN_DEF
) (
    input  logic               used,
    input  logic [AW-1:0]      addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]    value,
    output logic               ready
);

    logic hit;

    // Scan producers youngest first; the first match decides, older ones are stale.
    always_comb begin
        value = rf_data;
        ready = 1'b1;
        hit   = 1'b0;
        if (addr == AW'(ZERO_REG)) begin
            value = '0;
        end else if (used) begin
            for (int j = 0; j < NFWD; j++) begin
                if (!hit && fwd_valid[j] && fwd_we[j] && (fwd_dest[j*AW +: AW] == addr)) begin
                    hit = 1'b1;
                    if (fwd_ready[j]) begin
                        value = fwd_data[j*XLEN +: XLEN];
                    end else begin
                        ready = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage operand unit: one-entry pipeline register, operand bypass,
// hazard stall and a saturating stall-cycle counter.
module ds_operand_stage
    import mycpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int NFWD = NFWD_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    ds_operand_stage_if.slave    bus,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [31:0]          stall_cnt
);

    logic            held_valid;
    logic [AW-1:0]   held_rs;
    logic [AW-1:0]   held_rt;
    logic            held_rs_used;
    logic            held_rt_used;
    logic [AW-1:0]   held_dest;
    logic            held_we;
    logic [PW-1:0]   held_payload;

    logic [XLEN-1:0] rs_value;
    logic [XLEN-1:0] rt_value;
    logic            rs_ready;
    logic            rt_ready;
    logic            ready_go;
    logic            accept;
    logic [31:0]     stall_cnt_q;

    assign rf_raddr1 = held_rs;
    assign rf_raddr2 = held_rt;

    ds_fwd_select #(.NFWD(NFWD), .AW(AW), .XLEN(XLEN)) u_rs_sel (
        .used      (held_rs_used),
        .addr      (held_rs),
        .rf_data   (rf_rdata1),
        .fwd_valid (fwd_valid),
        .fwd_we    (fwd_we),
        .fwd_ready (fwd_ready),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .value     (rs_value),
        .ready     (rs_ready)
    );

    ds_fwd_select #(.NFWD(NFWD), .AW(AW), .XLEN(XLEN)) u_rt_sel (
        .used      (held_rt_used),
        .addr      (held_rt),
        .rf_data   (rf_rdata2),
        .fwd_valid (fwd_valid),
        .fwd_we    (fwd_we),
        .fwd_ready (fwd_ready),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .value     (rt_value),
        .ready     (rt_ready)
    );

    assign ready_go       = rs_ready & rt_ready;
    assign bus.in_allowin = !held_valid | (ready_go & bus.out_allowin);
    assign accept         = bus.in_valid & bus.in_allowin;

    assign bus.out_valid    = held_valid & ready_go & !flush;
    assign bus.out_rs_value = rs_value;
    assign bus.out_rt_value = rt_value;
    assign bus.out_dest     = held_dest;
    assign bus.out_we       = held_we;
    assign bus.out_payload  = held_payload;
    assign stall_cnt        = stall_cnt_q;

    // Pipeline register: flush kills the entry and wins over a same-cycle accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_valid   <= 1'b0;
            held_rs      <= '0;
            held_rt      <= '0;
            held_rs_used <= 1'b0;
            held_rt_used <= 1'b0;
            held_dest    <= '0;
            held_we      <= 1'b0;
            held_payload <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid   <= 1'b1;
            held_rs      <= bus.in_rs;
            held_rt      <= bus.in_rt;
            held_rs_used <= bus.in_rs_used;
            held_rt_used <= bus.in_rt_used;
            held_dest    <= bus.in_dest;
            held_we      <= bus.in_we;
            held_payload <= bus.in_payload;
        end else if (ready_go && bus.out_allowin) begin
            held_valid <= 1'b0;
        end
    end

    // Count hazard stall cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (held_valid && !ready_go && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Bench for ds_operand_stage: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the held instruction.
module tb_ds_operand_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NFWD = 3;
    localparam int PW   = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    logic flush;
    always #5 clk = ~clk;

    ds_operand_stage_if #(.XLEN(XLEN), .AW(AW), .PW(PW)) bus ();

    logic [AW-1:0]        rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]      fwd_valid, fwd_we, fwd_ready;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [31:0]          stall_cnt;

    logic [XLEN-1:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    ds_operand_stage #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD), .PW(PW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .bus       (bus),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .fwd_valid (fwd_valid),
        .fwd_we    (fwd_we),
        .fwd_ready (fwd_ready),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
        .stall_cnt (stall_cnt)
    );

    // ---------------- reference model state ----------------
    logic          m_valid;
    logic [AW-1:0] m_rs, m_rt, m_dest;
    logic          m_rs_used, m_rt_used, m_we;
    logic [PW-1:0] m_payload;
    logic [31:0]   m_stall;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
        m_rs_used = 0; m_rt_used = 0; m_we = 0; m_payload = 0; m_stall = 0;
    endtask

    // Operand rule: r0 -> 0; unused -> regfile; otherwise the youngest matching
    // producer decides (its data if ready, a stall if not); no match -> regfile.
    // Returns {ready, value}.
    function automatic logic [XLEN:0] resolve(input logic [AW-1:0] a, input logic used);
        int hits[$];
        if (a == 0) return {1'b1, {XLEN{1'b0}}};
        if (!used) return {1'b1, rf[a]};
        for (int j = 0; j < NFWD; j++)
            if (fwd_valid[j] && fwd_we[j] && fwd_dest[j*AW +: AW] == a) hits.push_back(j);
        if (hits.size() == 0) return {1'b1, rf[a]};
        if (fwd_ready[hits[0]]) return {1'b1, fwd_data[hits[0]*XLEN +: XLEN]};
        return {1'b0, {XLEN{1'b0}}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_fwd();
        fwd_valid = 0; fwd_we = 0; fwd_ready = 0; fwd_dest = 0; fwd_data = 0;
    endtask

    task automatic set_fwd(input int j, input logic rdy, input logic [AW-1:0] d, input logic [XLEN-1:0] x);
        fwd_valid[j] = 1'b1;
        fwd_we[j]    = 1'b1;
        fwd_ready[j] = rdy;
        fwd_dest[j*AW +: AW]     = d;
        fwd_data[j*XLEN +: XLEN] = x;
    endtask

    task automatic drive_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic rsu, input logic rtu, input logic [AW-1:0] d);
        bus.in_valid   = 1'b1;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_rs_used = rsu;
        bus.in_rt_used = rtu;
        bus.in_dest    = d;
        bus.in_we      = 1'b1;
        bus.in_payload = {$urandom, $urandom};
    endtask

    // One clock: compare every output against the model, advance the model, cross the edge.
    task automatic cycle();
        logic [XLEN:0] rsr, rtr;
        logic rg, acc;
        #2;
        rsr = resolve(m_rs, m_rs_used);
        rtr = resolve(m_rt, m_rt_used);
        rg  = rsr[XLEN] & rtr[XLEN];
        check("out_valid",  bus.out_valid,  m_valid & rg & !flush);
        check("in_allowin", bus.in_allowin, !m_valid | (rg & bus.out_allowin));
        if (rsr[XLEN]) check("rs_value", bus.out_rs_value, rsr[XLEN-1:0]);
        if (rtr[XLEN]) check("rt_value", bus.out_rt_value, rtr[XLEN-1:0]);
        check("out_dest",    bus.out_dest,    m_dest);
        check("out_we",      bus.out_we,      m_we);
        check("out_payload", bus.out_payload, m_payload);
        check("stall_cnt",   stall_cnt,       m_stall);
        check("rf_raddr1",   rf_raddr1,       m_rs);
        check("rf_raddr2",   rf_raddr2,       m_rt);
        acc = bus.in_valid & (!m_valid | (rg & bus.out_allowin));
        if (m_valid && !rg && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_rs = bus.in_rs; m_rt = bus.in_rt;
            m_rs_used = bus.in_rs_used; m_rt_used = bus.in_rt_used;
            m_dest = bus.in_dest; m_we = bus.in_we; m_payload = bus.in_payload;
        end else if (m_valid && rg && bus.out_allowin) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        resetn = 0; flush = 0;
        clear_fwd();
        bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rs_used = 0; bus.in_rt_used = 0;
        bus.in_dest = 0; bus.in_we = 0; bus.in_payload = 0; bus.out_allowin = 1;
        model_reset();

        // Reset state
        #12;
        check("rst_out_valid",  bus.out_valid, 1'b0);
        check("rst_in_allowin", bus.in_allowin, 1'b1);
        check("rst_rs_value",   bus.out_rs_value, 32'h0);
        check("rst_rt_value",   bus.out_rt_value, 32'h0);
        check("rst_stall",      stall_cnt, 32'h0);
        @(negedge clk);
        resetn = 1;
        cycle();

        // No hazard: plain regfile operands, valid one cycle after accept
        drive_instr(5'd3, 5'd4, 1, 1, 5'd9);
        cycle();
        bus.in_valid = 0;
        #1;
        check("nohaz_valid", bus.out_valid, 1'b1);
        check("nohaz_rs",    bus.out_rs_value, 32'h11);
        check("nohaz_rt",    bus.out_rt_value, 32'h22);
        check("nohaz_stall", stall_cnt, 32'h0);
        cycle();

        // Youngest producer wins when two match
        drive_instr(5'd5, 5'd6, 1, 0, 5'd1);
        set_fwd(0, 1, 5'd5, 32'hA);
        set_fwd(2, 1, 5'd5, 32'hC);
        cycle();
        bus.in_valid = 0;
        #1;
        check("young_rs", bus.out_rs_value, 32'hA);
        cycle();
        clear_fwd();

        // Load-use stall for three cycles, then the producer delivers
        drive_instr(5'd2, 5'd7, 1, 1, 5'd3);
        set_fwd(0, 0, 5'd7, 32'h0);
        cycle();
        bus.in_valid = 0;
        repeat (3) cycle();
        #1;
        check("lu_valid",   bus.out_valid, 1'b0);
        check("lu_allowin", bus.in_allowin, 1'b0);
        check("lu_stall",   stall_cnt, 32'd3);
        set_fwd(0, 1, 5'd7, 32'h55);
        #1;
        check("lu_rt",       bus.out_rt_value, 32'h55);
        check("lu_valid_go", bus.out_valid, 1'b1);
        cycle();
        clear_fwd();

        // r0 and unused operands never stall
        drive_instr(5'd0, 5'd8, 1, 0, 5'd4);
        set_fwd(0, 0, 5'd0, 32'h99);
        set_fwd(1, 0, 5'd8, 32'h77);
        cycle();
        bus.in_valid = 0;
        #1;
        check("r0_valid", bus.out_valid, 1'b1);
        check("r0_rs",    bus.out_rs_value, 32'h0);
        check("unused_rt", bus.out_rt_value, rf[8]);
        cycle();
        clear_fwd();

        // Backpressure, then flush drops the held instruction
        drive_instr(5'd1, 5'd2, 1, 1, 5'd6);
        cycle();
        bus.in_valid = 0;
        bus.out_allowin = 0;
        repeat (2) cycle();
        #1;
        check("bp_allowin", bus.in_allowin, 1'b0);
        check("bp_valid",   bus.out_valid, 1'b1);
        flush = 1;
        #1;
        check("fl_valid", bus.out_valid, 1'b0);
        cycle();
        flush = 0;
        bus.out_allowin = 1;
        #1;
        check("fl_allowin", bus.in_allowin, 1'b1);
        check("fl_gone",    bus.out_valid, 1'b0);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear_fwd();
            for (int j = 0; j < NFWD; j++) begin
                fwd_valid[j] = ($urandom_range(0, 3) != 0);
                fwd_we[j]    = ($urandom_range(0, 3) != 0);
                fwd_ready[j] = ($urandom_range(0, 2) != 0);
                fwd_dest[j*AW +: AW]     = AW'($urandom_range(0, 7));
                fwd_data[j*XLEN +: XLEN] = $urandom;
            end
            drive_instr(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 31)));
            bus.in_we       = 1'($urandom_range(0, 1));
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.out_allowin = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 31) == 0);
            if (flush) bus.in_valid = 0;
            cycle();
        end

        // Drain, then saturate the stall counter
        clear_fwd();
        flush = 0;
        bus.in_valid = 0;
        bus.out_allowin = 1;
        repeat (2) cycle();
        drive_instr(5'd7, 5'd3, 1, 1, 5'd2);
        set_fwd(0, 0, 5'd7, 32'h0);
        cycle();
        bus.in_valid = 0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        repeat (3) cycle();
        #1;
        check("sat_stall", stall_cnt, 32'hFFFF_FFFF);

        // Reset in the middle of the stall
        resetn = 0;
        model_reset();
        #1;
        check("mrst_valid",   bus.out_valid, 1'b0);
        check("mrst_allowin", bus.in_allowin, 1'b1);
        check("mrst_rs",      bus.out_rs_value, 32'h0);
        check("mrst_rt",      bus.out_rt_value, 32'h0);
        check("mrst_dest",    bus.out_dest, 5'd0);
        check("mrst_payload", bus.out_payload, 64'h0);
        check("mrst_stall",   stall_cnt, 32'h0);
        @(negedge clk);
        resetn = 1;
        clear_fwd();
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ds_operand_stage.md
# ds_operand_stage

Parametrised decode-stage operand unit for the in-order MIPS pipeline, sitting between fetch/decode and execute. It holds one decoded instruction in a valid/allowin pipeline register and reads source operands from the register file. It resolves RAW hazards against any number of downstream producer stages with youngest-first bypass, and stalls while a matching producer cannot yet supply its result. A saturating counter tracks stall cycles for performance analysis.

## Interface
- XLEN, 32, data width
- AW, 5, register-address width
- NFWD, 3, producer stages; index 0 = youngest (execute)
- PW, 64, opaque sideband payload width (alu_op, imm, pc, ...)

- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  kill held instruction
- in_valid  in  1  upstream instruction valid
- in_allowin  out  1  stage can accept
- in_rs, in_rt  in  AW  source register numbers
- in_rs_used, in_rt_used  in  1  operand actually read
- in_dest  in  AW  destination register; in_we  in  1  writes GPR
- in_payload  in  PW  sideband
- rf_raddr1, rf_raddr2  out  AW  regfile read addresses (held rs/rt)
- rf_rdata1, rf_rdata2  in  XLEN  regfile read data (combinational)
- fwd_valid, fwd_we, fwd_ready  in  NFWD  per-producer valid, writes GPR, result available
- fwd_dest  in  NFWD*AW  producer destinations, slice j = [j*AW +: AW]
- fwd_data  in  NFWD*XLEN  producer results, slice j = [j*XLEN +: XLEN]
- out_valid  out  1; out_allowin  in  1
- out_rs_value, out_rt_value  out  XLEN  resolved operands
- out_dest  out  AW; out_we  out  1; out_payload  out  PW
- stall_cnt  out  32  cycles stalled on hazard

## Operation
- Held register (valid, rs, rt, used bits, dest, we, payload) loads on in_valid & in_allowin.
- in_allowin = !held_valid | (ready_go & out_allowin).
- Per operand, resolved independently:
  - not used or addr == 0: value = 0 when addr == 0, else rf data; ready = 1.
  - else scan j = 0..NFWD-1; first j with fwd_valid[j] & fwd_we[j] & fwd_dest[j] == addr is the hit (youngest wins).
  - hit & fwd_ready[j]: value = fwd_data[j]; ready = 1.
  - hit & !fwd_ready[j]: ready = 0. Older matches are ignored because they are stale.
  - no hit: value = rf data.
- ready_go = rs_ready & rt_ready.
- out_valid = held_valid & ready_go & !flush. Outputs other than out_valid are unconditionally driven from held and resolved values.
- flush: held_valid <= 0 at the next edge. This overrides a simultaneous accept; upstream is flushed as well.
- stall_cnt increments when held_valid & !ready_go & !flush, saturates at 0xFFFF_FFFF, and never wraps.

## Timing
- Reset (async assert, sync release): held_valid = 0, all held fields = 0, stall_cnt = 0.
  - Consequences: out_valid = 0, in_allowin = 1, out values = 0.
- Latency: accept at edge N, out_valid possible in cycle N+1.
- Operand resolution is combinational from held state, fwd_*, and rf_*; there is no registered output stage.
- Back-to-back: when ready_go & out_allowin, a new accept in the same cycle gives one instruction per cycle.
- Output stalled (out_allowin = 0): held contents stable, in_allowin = 0. Values may change only if fwd_* changes.
- Producer becomes ready mid-stall: ready_go rises in the same cycle.
- Same register in rs and rt: both operands resolve to the identical source.
- Regfile write in the same cycle as read: the regfile owner guarantees write-through or a writeback producer in fwd_*. This block adds no bypass.
- Reset mid-stall: instruction dropped, counter cleared.

## Structure
- Shared package mycpu_pkg: default XLEN/AW, and the `ZERO_REG` constant.
- Sub-module ds_fwd_select: one operand's priority match and mux (NFWD, AW, XLEN). It is instantiated twice.
- Top holds the pipeline register, handshake, flush, and stall counter.

## Test plan
- No hazard: rs=3 (rf=0x11), rt=4 (rf=0x22), no fwd match → out 0x11/0x22, out_valid one cycle after accept, stall_cnt 0.
- Youngest priority: fwd0 and fwd2 both dest=5, ready, data 0xA / 0xC, rs=5 → out_rs_value = 0xA.
- Load-use stall: fwd0 dest=7, we, ready=0 for 3 cycles, rt=7 used.
  - During stall: out_valid = 0, in_allowin = 0, stall_cnt = 3.
  - fwd_ready=1 with data 0x55 → out_rt_value = 0x55, ready_go same cycle.
- r0 and unused operands: rs=0 with fwd0 dest=0 not ready → no stall, value 0; rt_used=0 with matching non-ready producer → no stall.
- Flush and backpressure: out_allowin=0 with held valid, then flush=1 → held_valid cleared next edge, in_allowin = 1 after.
- Reset and saturation: force stall_cnt to 0xFFFF_FFFE, stall 3 cycles → stays 0xFFFF_FFFF; resetn low mid-stall → all outputs 0, counter 0.
